// File: rtl/obstacle_scroller_pkg.sv
// Shared game constants, LFSR definition and the obstacle slot record.
// The ground scroller imports the same package so both agree on widths and screen size.
package obstacle_scroller_pkg;

    localparam int X_W           = 10;
    localparam int TYPE_W        = 2;
    localparam int GAME_SCREEN_W = 640;
    localparam int GAME_MIN_GAP  = 200;
    localparam int LFSR_W        = 16;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as register bits 15,13,12,10
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    typedef struct packed {
        logic              valid;
        logic [X_W-1:0]    x;
        logic [TYPE_W-1:0] kind;
    } slot_t;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/obstacle_scroller_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; steps every clock, seeded on reset.
module lfsr16
    import obstacle_scroller_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic [LFSR_W-1:0] lfsr_o
);

    logic [LFSR_W-1:0] lfsr_q;
    logic [LFSR_W-1:0] lfsr_d;

    assign lfsr_d = lfsr_next(lfsr_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/obstacle_scroller.sv
// Obstacle field: scrolls a fixed set of slots left each frame, retires off-screen
// slots and spawns new ones at the right edge with a random gap and sprite type.
module obstacle_scroller
    import obstacle_scroller_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    parameter int SCREEN_W  = GAME_SCREEN_W,
    parameter int MIN_GAP   = GAME_MIN_GAP
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        frame_tick,
    input  logic                        game_status,
    input  logic                        restart,
    input  logic [3:0]                  speed,
    output logic [NUM_SLOTS-1:0]        obs_valid,
    output logic [X_W*NUM_SLOTS-1:0]    obs_x,
    output logic [TYPE_W*NUM_SLOTS-1:0] obs_type,
    output logic                        spawn_pulse
);

    localparam logic [NUM_SLOTS-1:0] SLOT_ONE = NUM_SLOTS'(1);

    logic [LFSR_W-1:0]    lfsr_w;
    logic                 lfsr_unused;
    slot_t                slot_q [NUM_SLOTS];
    slot_t                slot_d [NUM_SLOTS];
    logic [X_W-1:0]       gap_q;
    logic [X_W-1:0]       gap_d;
    logic                 spawn_q;
    logic                 spawn_d;
    logic [NUM_SLOTS-1:0] free_w;
    logic [NUM_SLOTS-1:0] first_free_w;
    logic [X_W-1:0]       speed_ext;
    logic                 active_w;

    lfsr16 u_lfsr (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .lfsr_o (lfsr_w)
    );

    assign lfsr_unused = ^lfsr_w[LFSR_W-1:10];

    assign speed_ext = {{(X_W-4){1'b0}}, speed};
    assign active_w  = frame_tick & game_status & ~restart;

    // Free set is taken before this tick's retirements, so a slot freed now is not refilled now
    assign first_free_w = free_w & (~free_w + SLOT_ONE);
    assign spawn_d      = active_w && (gap_q <= speed_ext) && (free_w != '0);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign free_w[gi] = ~slot_q[gi].valid;

            always_comb begin
                slot_d[gi] = slot_q[gi];
                if (restart) begin
                    slot_d[gi].valid = 1'b0;
                end else if (active_w) begin
                    if (slot_q[gi].valid) begin
                        if (slot_q[gi].x >= speed_ext) begin
                            slot_d[gi].x = slot_q[gi].x - speed_ext;
                        end else begin
                            slot_d[gi].valid = 1'b0;
                        end
                    end else if (spawn_d && first_free_w[gi]) begin
                        slot_d[gi].valid = 1'b1;
                        slot_d[gi].x     = X_W'(SCREEN_W - 1);
                        slot_d[gi].kind  = lfsr_w[8 +: TYPE_W];
                    end
                end
            end

            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    slot_q[gi] <= '0;
                end else begin
                    slot_q[gi] <= slot_d[gi];
                end
            end

            assign obs_valid[gi]               = slot_q[gi].valid;
            assign obs_x[X_W*gi +: X_W]         = slot_q[gi].x;
            assign obs_type[TYPE_W*gi +: TYPE_W] = slot_q[gi].kind;
        end
    endgenerate

    // Gap saturates at zero and simply waits there while the field is full
    always_comb begin
        gap_d = gap_q;
        if (restart) begin
            gap_d = X_W'(MIN_GAP);
        end else if (active_w) begin
            if (spawn_d) begin
                gap_d = X_W'(MIN_GAP) + X_W'(lfsr_w[7:0]);
            end else if (gap_q > speed_ext) begin
                gap_d = gap_q - speed_ext;
            end else begin
                gap_d = '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            gap_q   <= X_W'(MIN_GAP);
            spawn_q <= 1'b0;
        end else begin
            gap_q   <= gap_d;
            spawn_q <= spawn_d;
        end
    end

    assign spawn_pulse = spawn_q;

endmodule

// File: doc/obstacle_scroller.md
OBSTACLE_SCROLLER -- requirements
Module: obstacle_scroller

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4: obstacle slot count.
REQ-002 SHALL have parameter SCREEN_W, default 640: x coordinate where new obstacles spawn.
REQ-003 SHALL have parameter MIN_GAP, default 200: minimum pixel spacing between spawns.
REQ-004 SHALL have port CLK  input  1: single clock; all state on posedge CLK.
REQ-005 SHALL have port RST_N  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port frame_tick  input  1: one-cycle pulse, once per video frame.
REQ-007 SHALL have port game_status  input  1: 1 = running, 0 = frozen.
REQ-008 SHALL have port restart  input  1: one-cycle pulse that clears the field.
REQ-009 SHALL have port speed  input  4: pixels scrolled per frame_tick; same value the ground scroller uses.
REQ-010 SHALL have port obs_valid  output  NUM_SLOTS: per-slot occupied flag.
REQ-011 SHALL have port obs_x  output  10*NUM_SLOTS: per-slot left-edge x; slot i at bits [10i+9:10i].
REQ-012 SHALL have port obs_type  output  2*NUM_SLOTS: per-slot sprite type (0..3).
REQ-013 SHALL have port spawn_pulse  output  1: high for exactly one cycle when a slot is filled.

Function
REQ-014 SHALL update state only on a cycle with frame_tick=1, game_status=1 and restart=0 (an "active tick"); all other cycles hold slots and gap counter.
REQ-015 SHALL, on an active tick, compute x-speed for each valid slot with x >= speed and clear obs_valid for each valid slot with x < speed (off-screen retire).
REQ-016 SHALL keep a 10-bit gap counter that is reduced by speed on each active tick and saturates at 0.
REQ-017 SHALL spawn on an active tick when gap <= speed and at least one slot was free before that tick.
REQ-018 SHALL fill the lowest-index free slot on spawn with x=SCREEN_W-1, type=lfsr[9:8], valid=1.
REQ-019 SHALL reload gap to MIN_GAP + lfsr[7:0] on spawn (range 200..455 at defaults).
REQ-020 SHALL not reuse a slot retired on a tick for a spawn on that same tick; the spawn waits for the next active tick.
REQ-021 SHALL hold gap at 0 when no slot is free, and spawn on the first active tick with a free slot.
REQ-022 SHALL freeze all positions and gap when speed=0; a spawn may still occur if gap is already 0 and a slot is free.
REQ-023 SHALL run a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1) that advances every clock regardless of game_status; it never reaches all-zero.
REQ-024 SHALL assert spawn_pulse in the cycle after the active tick that spawns; it is 0 otherwise.
REQ-025 SHALL make updated obs_valid/obs_x/obs_type visible one cycle after the active tick (registered outputs).
REQ-026 SHALL, on restart=1, clear all obs_valid, set gap to MIN_GAP and drive spawn_pulse to 0 next cycle; restart takes priority over a coincident frame_tick.

Reset
REQ-027 SHALL, while RST_N=0 (asynchronous), set obs_valid=0, obs_x=0, obs_type=0, spawn_pulse=0, gap=MIN_GAP and lfsr=16'hACE1.
REQ-028 SHALL resume normal operation on the first posedge CLK after RST_N deasserts, with no initial blocks relied on.

Structure
REQ-029 SHALL take SCREEN_W, MIN_GAP, X_W=10, TYPE_W=2 and the LFSR seed/taps from the shared game package, which the ground scroller also uses.
REQ-030 SHALL implement the LFSR as sub-module lfsr16; slot update and spawn logic SHALL stay inline.

Verification
REQ-031 SHALL verify: reset, then game_status=1, speed=4, 50 ticks -> first spawn at tick 50 (gap 200/4); slot0 x=639 with spawn_pulse one cycle later.
REQ-032 SHALL verify: slot0 x=3, speed=4, active tick -> obs_valid[0]=0 and no x update; with x=4 -> x=0 and still valid.
REQ-033 SHALL verify: all 4 slots valid, gap=0, 10 ticks -> no spawn and gap stays 0; when slot2 retires, spawn lands in slot2 on the following tick.
REQ-034 SHALL verify: frame_tick with game_status=0, or with speed=0 and gap>0 -> every output unchanged.
REQ-035 SHALL verify: restart and frame_tick in the same cycle -> obs_valid=0, gap=200, no spawn_pulse.
REQ-036 SHALL verify: RST_N driven low mid-tick between clock edges -> outputs zero immediately, without waiting for CLK.
